// File: rtl/regfile_cmd_ctrl.sv
// regfile_cmd_ctrl: decodes UART write/read frames into register file accesses and returns read data as two bytes
module regfile_cmd_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VLD,
    output logic [7:0]        TX_DATA,
    output logic              TX_VLD,
    input  logic              TX_RDY,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData,
    output logic              CMD_ERR
);
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC, RD_ADDR, RD_EXEC, RD_CAP, TX_LO, TX_HI
    } state_t;
    state_t state, nxt;
    logic err, lat_addr, lat_lo, lat_hi, xfer, bad_addr;
    logic [7:0] tx_hi;
    assign xfer = TX_VLD && TX_RDY;
    assign bad_addr = RX_DATA[7:ADDR_W] != '0;
    always_comb begin
        nxt = state;
        err = 1'b0;
        lat_addr = 1'b0;
        lat_lo = 1'b0;
        lat_hi = 1'b0;
        case (state)
            IDLE: if (RX_VLD) begin
                if (RX_DATA == 8'hAA) nxt = WR_ADDR;
                else if (RX_DATA == 8'hBB) nxt = RD_ADDR;
                else err = 1'b1;
            end
            WR_ADDR, RD_ADDR: if (RX_VLD) begin
                if (bad_addr) begin
                    err = 1'b1;
                    nxt = IDLE;
                end else begin
                    lat_addr = 1'b1;
                    nxt = (state == WR_ADDR) ? WR_LO : RD_EXEC;
                end
            end
            WR_LO: if (RX_VLD) begin
                lat_lo = 1'b1;
                nxt = WR_HI;
            end
            WR_HI: if (RX_VLD) begin
                lat_hi = 1'b1;
                nxt = WR_EXEC;
            end
            WR_EXEC: nxt = IDLE;
            RD_EXEC: nxt = RD_CAP;
            RD_CAP:  nxt = TX_LO;
            TX_LO:   nxt = xfer ? TX_HI : TX_LO;
            TX_HI:   nxt = xfer ? IDLE : TX_HI;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            WrEn <= 1'b0;
            RdEn <= 1'b0;
            TX_VLD <= 1'b0;
            CMD_ERR <= 1'b0;
            TX_DATA <= '0;
            Address <= '0;
            WrData <= '0;
            tx_hi <= '0;
        end else begin
            state <= nxt;
            WrEn <= nxt == WR_EXEC;
            RdEn <= nxt == RD_EXEC;
            TX_VLD <= nxt == TX_LO || nxt == TX_HI;
            CMD_ERR <= err;
            if (lat_addr) Address <= RX_DATA[ADDR_W-1:0];
            if (lat_lo) WrData[7:0] <= RX_DATA;
            if (lat_hi) WrData[DATA_W-1:8] <= RX_DATA;
            if (state == RD_CAP) begin
                TX_DATA <= RdData[7:0];
                tx_hi <= RdData[DATA_W-1:8];
            end else if (state == TX_LO && xfer) begin
                TX_DATA <= tx_hi;
            end
        end
    end
endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// tb_regfile_cmd_ctrl: randomized frame stimulus checked against a frame-level register file model
module tb_regfile_cmd_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA = '0;
    logic        RX_VLD = 1'b0;
    logic        TX_RDY = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VLD, WrEn, RdEn, CMD_ERR;
    logic [2:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData = '0;
    logic [15:0] mem [8];
    logic [15:0] ref_mem [8];
    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    regfile_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .CMD_ERR(CMD_ERR)
    );

    // Register file the controller talks to
    always @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick;
        RX_DATA = b;
        RX_VLD = 1'b1;
        tick;
        RX_VLD = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, WrEn, 0);
        check({tag, "_rd_en"}, RdEn, 0);
        check({tag, "_tx_vld"}, TX_VLD, 0);
        check({tag, "_tx_data"}, TX_DATA, 0);
        check({tag, "_cmd_err"}, CMD_ERR, 0);
        check({tag, "_addr"}, Address, 0);
        check({tag, "_wr_data"}, WrData, 0);
    endtask

    task automatic wr_frame(input logic [2:0] a, input logic [15:0] d, input int g);
        send(8'hAA, g);
        send({5'd0, a}, g);
        send(d[7:0], g);
        check("wr_early", WrEn, 0);
        send(d[15:8], g);
        check("wr_en", WrEn, 1);
        check("wr_addr", Address, a);
        check("wr_data", WrData, d);
        check("wr_rd_en", RdEn, 0);
        tick;
        check("wr_en_drop", WrEn, 0);
        ref_mem[a] = d;
    endtask

    task automatic rd_frame(input logic [2:0] a, input int g, input int ns0, input int ns1);
        logic [15:0] e;
        e = ref_mem[a];
        send(8'hBB, g);
        send({5'd0, a}, g);
        check("rd_en", RdEn, 1);
        check("rd_addr", Address, a);
        check("rd_wr_en", WrEn, 0);
        tick;
        check("rd_en_drop", RdEn, 0);
        check("tx_early", TX_VLD, 0);
        tick;
        for (int i = 0; i < 2; i++) begin
            int ns;
            ns = (i == 0) ? ns0 : ns1;
            for (int s = 0; s <= ns; s++) begin
                check("tx_vld", TX_VLD, 1);
                check("tx_byte", TX_DATA, (i == 0) ? e[7:0] : e[15:8]);
                TX_RDY = (s == ns);
                RX_DATA = 8'($urandom);
                RX_VLD = (s == 0) || ($urandom_range(0, 1) == 1);
                tick;
                RX_VLD = 1'b0;
                check("tx_ignored_rx", CMD_ERR, 0);
            end
        end
        TX_RDY = 1'b0;
        check("tx_done", TX_VLD, 0);
    endtask

    task automatic err_op(input logic [7:0] b, input int g);
        send(b, g);
        check("err_op", CMD_ERR, 1);
        tick;
        check("err_op_pulse", CMD_ERR, 0);
    endtask

    task automatic err_addr(input logic [7:0] op, input logic [7:0] a, input int g);
        send(op, g);
        check("op_no_err", CMD_ERR, 0);
        send(a, g);
        check("err_addr", CMD_ERR, 1);
        check("err_wr_en", WrEn, 0);
        check("err_rd_en", RdEn, 0);
        tick;
        check("err_addr_pulse", CMD_ERR, 0);
        check("err_wr_en2", WrEn, 0);
        check("err_rd_en2", RdEn, 0);
    endtask

    initial begin
        logic [7:0] b;
        tick;
        check_all_zero("reset");
        tick;
        RST = 1'b1;
        tick;
        send(8'hAA, 0);
        send(8'h03, 0);
        RST = 1'b0;
        #1;
        check_all_zero("mid_rst");
        #1;
        RST = 1'b1;
        tick;
        wr_frame(3'd3, 16'hBEEF, 0);
        for (int a = 0; a < 8; a++) wr_frame(3'(a), 16'($urandom), $urandom_range(0, 2));
        wr_frame(3'd5, 16'h1234, 0);
        rd_frame(3'd5, 0, 0, 0);
        rd_frame(3'd5, 0, 4, 0);
        err_op(8'h55, 0);
        err_addr(8'hAA, 8'h09, 0);
        wr_frame(3'd1, 16'hA5C3, 0);
        rd_frame(3'd1, 1, 1, 2);
        // Reset while the high byte is being offered
        send(8'hBB, 0);
        send(8'h05, 0);
        tick;
        tick;
        TX_RDY = 1'b1;
        tick;
        TX_RDY = 1'b0;
        check("txhi_vld", TX_VLD, 1);
        check("txhi_data", TX_DATA, 8'h12);
        RST = 1'b0;
        #1;
        check("txhi_rst_vld", TX_VLD, 0);
        check_all_zero("txhi_rst");
        tick;
        RST = 1'b1;
        TX_RDY = 1'b1;
        repeat (3) begin
            tick;
            check("post_rst_tx", TX_VLD, 0);
        end
        TX_RDY = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int r, g;
            r = $urandom_range(0, 9);
            g = $urandom_range(0, 2);
            if (r < 4) wr_frame(3'($urandom_range(0, 7)), 16'($urandom), g);
            else if (r < 8) rd_frame(3'($urandom_range(0, 7)), g, $urandom_range(0, 4), $urandom_range(0, 4));
            else if (r == 8) begin
                do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
                err_op(b, g);
            end else err_addr(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB, 8'($urandom_range(8, 255)), g);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
